interrupt_ack_sequencer: RTL and testbench
==========================================

Name: interrupt_ack_sequencer

Overview:
- Control stage directly upstream of the in-service register in the 8259-style PIC.
- Resolves the highest-priority pending request against the current highest in-service level and raises INT to the CPU.
- Runs the two-pulse 8086 INTA handshake, producing the latch_in_service/interrupt pair that sets the ISR, plus the end_of_interrupt mask that clears it.
- Owns the rotating priority pointer (priority_rotate) and decodes OCW2 EOI/rotate commands.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for inta_n (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- inta_n  in  1  CPU interrupt acknowledge, active-low, asynchronous to clk.
- masked_irr  in  8  pending requests after the mask; bit n is IRn.
- highest_level_in_service  in  8  one-hot highest in-service level from the ISR.
- in_service_register  in  8  current ISR contents.
- ocw2_wr  in  1  single-cycle strobe; ocw2_data is valid this cycle.
- ocw2_data  in  8  [7:5] = R, SL, EOI; [2:0] = level L.
- vector_base  in  5  T7..T3 from ICW2.
- auto_eoi  in  1  AEOI mode from ICW4.
- int_out  out  1  interrupt request to the CPU.
- latch_in_service  out  1  one-cycle pulse; the ISR ORs in interrupt.
- interrupt  out  8  one-hot level being acknowledged.
- clear_request  out  8  one-cycle pulse that clears the edge-latched IRR bit.
- end_of_interrupt  out  8  one-cycle mask that clears ISR bits.
- priority_rotate  out  3  rotation pointer; 3'b111 means IR0 is highest.
- data_out  out  8  vector byte.
- data_out_en  out  1  bus driver enable.

Behaviour:
- Reset values:
  - priority_rotate = 3'b111.
  - All other outputs 0.
  - FSM in IDLE.
  - Synchroniser flops at 1.
- Priority resolution (combinational):
  - Rotate masked_irr and highest_level_in_service by priority_rotate; the lowest rotated bit is highest priority.
  - Candidate = highest pending request whose rotated priority is strictly above the rotated highest-in-service bit (any request qualifies if the ISR is empty).
  - Un-rotate the candidate back to one-hot.
- int_out: registered. Set in IDLE when a candidate exists; cleared on the first INTA falling edge.
- INTA edge detect: falling/rising edges of inta_n are taken after SYNC_STAGES flops plus one delay flop.
- FSM states: IDLE, ACK1, ACK2.
- IDLE -> ACK1 on a falling edge:
  - Capture the candidate into ack_level.
  - If the candidate is non-zero: pulse latch_in_service and clear_request for one cycle, and hold interrupt = candidate during that cycle.
  - If the candidate is zero (spurious), capture IR7 and do not set the ISR.
- ACK1 -> ACK2 on the next falling edge:
  - data_out = {vector_base, encoded ack_level}.
  - data_out_en high until the rising edge of inta_n, then the FSM returns to IDLE.
- End of sequence with AEOI (see Optional Feature): on the ACK2 rising edge, pulse end_of_interrupt = ack_level, unless the acknowledge was spurious.
- A falling edge in ACK2 before the rising edge is ignored.
- OCW2 decode, applied when ocw2_wr is high (any FSM state):
  - 001, non-specific EOI: end_of_interrupt = highest_level_in_service.
  - 011, specific EOI: end_of_interrupt = one-hot(L).
  - 101, rotate on non-specific EOI: as 001; priority_rotate = encoded highest level; no rotation if the ISR is empty.
  - 111, rotate on specific EOI: as 011; priority_rotate = L.
  - 110, set priority: priority_rotate = L; no EOI.
  - Other codes: no action.
- Simultaneous events: an OCW2 EOI and an AEOI pulse in the same cycle are ORed.
- Reset mid-sequence: return to IDLE immediately, drop data_out_en, cancel any pending pulse.

Optional Feature:
- Macro PIC_AUTO_EOI_EN.
- Defined: auto_eoi=1 generates the end-of-ACK2 end_of_interrupt pulse described above.
- Undefined: auto_eoi is ignored; the ISR is cleared only by OCW2.

Decomposition:
- Shared package pic_pkg:
  - OCW2 command encodings.
  - FSM state typedef.
  - Rotate, un-rotate, priority-resolve and one-hot encode/decode functions, shared with the ISR.
- Natural sub-module: pic_priority_resolver (combinational candidate selection).

Test Plan:
- Reset, then IR3 pending, ISR=0 -> int_out=1; first INTA gives interrupt=8'h08 with a latch_in_service pulse; second INTA with vector_base=5'h08 gives data_out=8'h43.
- ISR=8'h04, IR5 and IR1 pending, priority_rotate=7 -> candidate IR1; IR5 alone gives no int_out.
- IRR drops before the first INTA -> no latch pulse; data_out = {vector_base,3'd7}.
- OCW2 8'hA0 with ISR highest=8'h10 -> end_of_interrupt=8'h10; priority_rotate=4; afterwards IR5 beats IR0.
- PIC_AUTO_EOI_EN defined, auto_eoi=1, IR2 acknowledged -> end_of_interrupt=8'h04 pulse on the INTA rising edge.
- Reset asserted during ACK2 -> data_out_en=0 immediately; state IDLE; priority_rotate=7.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared 8259 PIC definitions: OCW2 command codes, acknowledge FSM states and
// rotate / priority / one-hot helpers used by the sequencer and the ISR.
package pic_pkg;

  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_SPEC_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_ROT_SPEC_EOI = 3'b111;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;

  localparam logic [2:0] ROTATE_RESET = 3'b111;
  localparam logic [7:0] SPURIOUS_LEVEL = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } ack_state_t;

  // rot names the lowest-priority level, so the shift is rot+1: with 3'b111
  // nothing moves and IR0 stays highest.
  function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] rot);
    logic [7:0] r;
    logic [2:0] amt;
    logic [2:0] idx;
    amt = rot + 3'd1;
    for (int i = 0; i < 8; i++) begin
      idx  = 3'(i) + amt;
      r[i] = v[idx];
    end
    return r;
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] rot);
    logic [7:0] r;
    logic [2:0] amt;
    logic [2:0] idx;
    amt = rot + 3'd1;
    r   = '0;
    for (int i = 0; i < 8; i++) begin
      idx    = 3'(i) + amt;
      r[idx] = v[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] isolate_lowest(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  // Operates in the rotated domain. An empty ISR yields an all-ones mask
  // because 0 - 1 wraps.
  function automatic logic [7:0] resolve_priority(input logic [7:0] req, input logic [7:0] isr);
    logic [7:0] above_isr;
    above_isr = isolate_lowest(isr) - 8'd1;
    return isolate_lowest(req & above_isr);
  endfunction

  function automatic logic [2:0] encode_onehot(input logic [7:0] v);
    logic [2:0] l;
    l = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) l = 3'(i);
    end
    return l;
  endfunction

  function automatic logic [7:0] decode_level(input logic [2:0] l);
    return 8'd1 << l;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Sequencer bus bundle: CPU INTA/vector side, ISR/IRR side and OCW2/ICW inputs.
// master = the sequencer, slave = the surrounding PIC logic (or a bench).
interface interrupt_ack_sequencer_if;
  logic       inta_n;
  logic [7:0] masked_irr;
  logic [7:0] highest_level_in_service;
  logic [7:0] in_service_register;
  logic       ocw2_wr;
  logic [7:0] ocw2_data;
  logic [4:0] vector_base;
  logic       auto_eoi;

  logic       int_out;
  logic       latch_in_service;
  logic [7:0] interrupt;
  logic [7:0] clear_request;
  logic [7:0] end_of_interrupt;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    input  inta_n, masked_irr, highest_level_in_service, in_service_register,
           ocw2_wr, ocw2_data, vector_base, auto_eoi,
    output int_out, latch_in_service, interrupt, clear_request,
           end_of_interrupt, priority_rotate, data_out, data_out_en
  );

  modport slave (
    output inta_n, masked_irr, highest_level_in_service, in_service_register,
           ocw2_wr, ocw2_data, vector_base, auto_eoi,
    input  int_out, latch_in_service, interrupt, clear_request,
           end_of_interrupt, priority_rotate, data_out, data_out_en
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational candidate selection: highest pending request that outranks the
// highest in-service level under the current rotation; zero when none qualifies.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] masked_irr,
  input  logic [7:0] highest_level_in_service,
  input  logic [2:0] priority_rotate,
  output logic [7:0] candidate
);

  logic [7:0] rot_req;
  logic [7:0] rot_isr;
  logic [7:0] rot_win;

  always_comb begin
    rot_req   = rotate_right(masked_irr, priority_rotate);
    rot_isr   = rotate_right(highest_level_in_service, priority_rotate);
    rot_win   = resolve_priority(rot_req, rot_isr);
    candidate = rotate_left(rot_win, priority_rotate);
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259 INT/INTA sequencer: raises INT, runs the two-pulse INTA handshake, decodes OCW2.
// Outputs registered; INTA edges act SYNC_STAGES+1 clocks late. AEOI needs PIC_AUTO_EOI_EN.
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic                        clk,
  input logic                        reset,
  interrupt_ack_sequencer_if.master  bus
);

  logic [SYNC_STAGES-1:0] inta_sync;
  logic                   inta_dly;
  logic                   inta_fall;
  logic                   inta_rise;
  logic [7:0]             candidate;

  ack_state_t state, state_nxt;

  logic       int_out_q, int_out_nxt;
  logic       latch_q, latch_nxt;
  logic [7:0] interrupt_q, interrupt_nxt;
  logic [7:0] clear_q, clear_nxt;
  logic [7:0] eoi_q, eoi_nxt;
  logic [2:0] rotate_q, rotate_nxt;
  logic [7:0] data_out_q, data_out_nxt;
  logic       data_en_q, data_en_nxt;
  logic [7:0] ack_level_q, ack_level_nxt;
  logic       spurious_q, spurious_nxt;
  logic [7:0] ocw2_eoi;
  logic [7:0] aeoi_mask;
  logic       unused_ocw2;

  // Flops come out of reset at 1 so a low inta_n during reset is not seen as an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inta_sync <= '1;
      inta_dly  <= 1'b1;
    end else begin
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], bus.inta_n};
      inta_dly  <= inta_sync[SYNC_STAGES-1];
    end
  end

  assign inta_fall = inta_dly & ~inta_sync[SYNC_STAGES-1];
  assign inta_rise = ~inta_dly & inta_sync[SYNC_STAGES-1];

  pic_priority_resolver u_resolver (
    .masked_irr               (bus.masked_irr),
    .highest_level_in_service (bus.highest_level_in_service),
    .priority_rotate          (rotate_q),
    .candidate                (candidate)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      int_out_q   <= 1'b0;
      latch_q     <= 1'b0;
      interrupt_q <= '0;
      clear_q     <= '0;
      eoi_q       <= '0;
      rotate_q    <= ROTATE_RESET;
      data_out_q  <= '0;
      data_en_q   <= 1'b0;
      ack_level_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      int_out_q   <= int_out_nxt;
      latch_q     <= latch_nxt;
      interrupt_q <= interrupt_nxt;
      clear_q     <= clear_nxt;
      eoi_q       <= eoi_nxt;
      rotate_q    <= rotate_nxt;
      data_out_q  <= data_out_nxt;
      data_en_q   <= data_en_nxt;
      ack_level_q <= ack_level_nxt;
      spurious_q  <= spurious_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    int_out_nxt   = int_out_q;
    latch_nxt     = 1'b0;
    interrupt_nxt = '0;
    clear_nxt     = '0;
    data_out_nxt  = data_out_q;
    data_en_nxt   = data_en_q;
    ack_level_nxt = ack_level_q;
    spurious_nxt  = spurious_q;
    aeoi_mask     = '0;

    case (state)
      IDLE: begin
        int_out_nxt = |candidate;
        if (inta_fall) begin
          int_out_nxt = 1'b0;
          state_nxt   = ACK1;
          if (|candidate) begin
            ack_level_nxt = candidate;
            spurious_nxt  = 1'b0;
            latch_nxt     = 1'b1;
            interrupt_nxt = candidate;
            clear_nxt     = candidate;
          end else begin
            // Request vanished before INTA: answer with IR7, leave the ISR alone.
            ack_level_nxt = SPURIOUS_LEVEL;
            spurious_nxt  = 1'b1;
          end
        end
      end
      ACK1: begin
        int_out_nxt = 1'b0;
        if (inta_fall) begin
          state_nxt    = ACK2;
          data_out_nxt = {bus.vector_base, encode_onehot(ack_level_q)};
          data_en_nxt  = 1'b1;
        end
      end
      ACK2: begin
        int_out_nxt = 1'b0;
        if (inta_rise) begin
          state_nxt    = IDLE;
          data_en_nxt  = 1'b0;
          data_out_nxt = '0;
`ifdef PIC_AUTO_EOI_EN
          if (bus.auto_eoi && !spurious_q) aeoi_mask = ack_level_q;
`endif
        end
      end
      default: begin
        state_nxt   = IDLE;
        int_out_nxt = 1'b0;
        data_en_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    ocw2_eoi   = '0;
    rotate_nxt = rotate_q;
    if (bus.ocw2_wr) begin
      case (bus.ocw2_data[7:5])
        OCW2_NS_EOI:   ocw2_eoi = bus.highest_level_in_service;
        OCW2_SPEC_EOI: ocw2_eoi = decode_level(bus.ocw2_data[2:0]);
        OCW2_ROT_NS_EOI: begin
          ocw2_eoi = bus.highest_level_in_service;
          if (|bus.in_service_register)
            rotate_nxt = encode_onehot(bus.highest_level_in_service);
        end
        OCW2_ROT_SPEC_EOI: begin
          ocw2_eoi   = decode_level(bus.ocw2_data[2:0]);
          rotate_nxt = bus.ocw2_data[2:0];
        end
        OCW2_SET_PRI: rotate_nxt = bus.ocw2_data[2:0];
        default: ;
      endcase
    end
    eoi_nxt = ocw2_eoi | aeoi_mask;
  end

  assign unused_ocw2 = ^bus.ocw2_data[4:3];

`ifdef PIC_AUTO_EOI_EN
`else
  logic unused_aeoi;
  assign unused_aeoi = bus.auto_eoi ^ spurious_q;
`endif

  assign bus.int_out          = int_out_q;
  assign bus.latch_in_service = latch_q;
  assign bus.interrupt        = interrupt_q;
  assign bus.clear_request    = clear_q;
  assign bus.end_of_interrupt = eoi_q;
  assign bus.priority_rotate  = rotate_q;
  assign bus.data_out         = data_out_q;
  assign bus.data_out_en      = data_en_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: INTA handshake, priority, OCW2, AEOI, reset.
module tb_interrupt_ack_sequencer;
  import pic_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  interrupt_ack_sequencer_if bus();

  interrupt_ack_sequencer #(.SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two sync flops plus the delay flop: an edge shows up in outputs 3 clocks later.
  task automatic inta(input logic v);
    bus.inta_n = v;
    tick(3);
  endtask

  task automatic ocw2(input logic [7:0] d);
    bus.ocw2_wr   = 1'b1;
    bus.ocw2_data = d;
    tick(1);
    bus.ocw2_wr   = 1'b0;
    bus.ocw2_data = 8'h00;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.inta_n = 1'b1;
    bus.masked_irr = 8'h00;
    bus.highest_level_in_service = 8'h00;
    bus.in_service_register = 8'h00;
    bus.ocw2_wr = 1'b0;
    bus.ocw2_data = 8'h00;
    bus.vector_base = 5'h08;
    bus.auto_eoi = 1'b0;
    tick(2);
    check("rst_rotate", 32'(bus.priority_rotate), 32'h7);
    check("rst_int", 32'(bus.int_out), 32'h0);
    check("rst_den", 32'(bus.data_out_en), 32'h0);
    check("rst_state", 32'(u_dut.state), 32'(IDLE));
    reset = 1'b0;
    tick(1);

    // IR3, empty ISR: full handshake, vector 0x43.
    bus.masked_irr = 8'h08;
    tick(1);
    check("t1_int", 32'(bus.int_out), 32'h1);
    inta(1'b0);
    check("t1_latch", 32'(bus.latch_in_service), 32'h1);
    check("t1_irq", 32'(bus.interrupt), 32'h08);
    check("t1_clr", 32'(bus.clear_request), 32'h08);
    check("t1_int_clr", 32'(bus.int_out), 32'h0);
    tick(1);
    check("t1_latch_pulse", 32'(bus.latch_in_service), 32'h0);
    bus.masked_irr = 8'h00;
    bus.in_service_register = 8'h08;
    bus.highest_level_in_service = 8'h08;
    inta(1'b1);
    inta(1'b0);
    check("t1_den", 32'(bus.data_out_en), 32'h1);
    check("t1_vec", 32'(bus.data_out), 32'h43);
    inta(1'b1);
    check("t1_den_off", 32'(bus.data_out_en), 32'h0);
    check("t1_idle", 32'(u_dut.state), 32'(IDLE));
    check("t1_no_aeoi", 32'(bus.end_of_interrupt), 32'h0);

    // ISR=IR2; IR5 and IR1 pending: only IR1 outranks IR2.
    bus.in_service_register = 8'h04;
    bus.highest_level_in_service = 8'h04;
    bus.masked_irr = 8'h22;
    tick(1);
    check("t2_int", 32'(bus.int_out), 32'h1);
    inta(1'b0);
    check("t2_irq", 32'(bus.interrupt), 32'h02);
    bus.masked_irr = 8'h20;
    inta(1'b1);
    inta(1'b0);
    check("t2_vec", 32'(bus.data_out), 32'h41);
    inta(1'b1);
    tick(2);
    check("t2_ir5_blocked", 32'(bus.int_out), 32'h0);

    // Request drops before INTA: spurious IR7, no latch.
    bus.in_service_register = 8'h00;
    bus.highest_level_in_service = 8'h00;
    bus.masked_irr = 8'h08;
    tick(1);
    check("t3_int", 32'(bus.int_out), 32'h1);
    bus.masked_irr = 8'h00;
    inta(1'b0);
    check("t3_no_latch", 32'(bus.latch_in_service), 32'h0);
    check("t3_no_irq", 32'(bus.interrupt), 32'h00);
    inta(1'b1);
    inta(1'b0);
    check("t3_vec", 32'(bus.data_out), 32'h47);
    inta(1'b1);

    // Rotate on non-specific EOI with IR4 in service.
    bus.in_service_register = 8'h10;
    bus.highest_level_in_service = 8'h10;
    ocw2(8'hA0);
    check("t4_eoi", 32'(bus.end_of_interrupt), 32'h10);
    check("t4_rotate", 32'(bus.priority_rotate), 32'h4);
    tick(1);
    check("t4_eoi_pulse", 32'(bus.end_of_interrupt), 32'h00);
    bus.in_service_register = 8'h00;
    bus.highest_level_in_service = 8'h00;
    bus.masked_irr = 8'h21;
    tick(1);
    check("t4_int", 32'(bus.int_out), 32'h1);
    inta(1'b0);
    check("t4_ir5_wins", 32'(bus.interrupt), 32'h20);
    bus.masked_irr = 8'h00;
    inta(1'b1);
    inta(1'b0);
    check("t4_vec", 32'(bus.data_out), 32'h45);
    inta(1'b1);

    // Remaining OCW2 commands.
    ocw2(8'h63);
    check("t4_spec_eoi", 32'(bus.end_of_interrupt), 32'h08);
    check("t4_spec_norot", 32'(bus.priority_rotate), 32'h4);
    ocw2(8'hE2);
    check("t4_rot_spec_eoi", 32'(bus.end_of_interrupt), 32'h04);
    check("t4_rot_spec", 32'(bus.priority_rotate), 32'h2);
    ocw2(8'hC7);
    check("t4_setpri_noeoi", 32'(bus.end_of_interrupt), 32'h00);
    check("t4_setpri", 32'(bus.priority_rotate), 32'h7);
    ocw2(8'hA0);
    check("t4_rot_empty", 32'(bus.priority_rotate), 32'h7);

    // Automatic EOI on the closing INTA rising edge for IR2.
    bus.auto_eoi = 1'b1;
    bus.masked_irr = 8'h04;
    tick(1);
    inta(1'b0);
    check("t5_irq", 32'(bus.interrupt), 32'h04);
    bus.masked_irr = 8'h00;
    inta(1'b1);
    inta(1'b0);
    check("t5_vec", 32'(bus.data_out), 32'h42);
    inta(1'b1);
`ifdef PIC_AUTO_EOI_EN
    check("t5_aeoi", 32'(bus.end_of_interrupt), 32'h04);
`else
    check("t5_aeoi_off", 32'(bus.end_of_interrupt), 32'h00);
`endif
    tick(1);
    check("t5_aeoi_pulse", 32'(bus.end_of_interrupt), 32'h00);
    bus.auto_eoi = 1'b0;

    // Reset while the vector is on the bus.
    ocw2(8'hC3);
    check("t6_rot3", 32'(bus.priority_rotate), 32'h3);
    bus.masked_irr = 8'h08;
    tick(1);
    inta(1'b0);
    inta(1'b1);
    inta(1'b0);
    check("t6_den", 32'(bus.data_out_en), 32'h1);
    check("t6_vec", 32'(bus.data_out), 32'h43);
    reset = 1'b1;
    #1;
    check("t6_den_rst", 32'(bus.data_out_en), 32'h0);
    check("t6_state_rst", 32'(u_dut.state), 32'(IDLE));
    check("t6_rot_rst", 32'(bus.priority_rotate), 32'h7);
    check("t6_int_rst", 32'(bus.int_out), 32'h0);
    tick(2);
    reset = 1'b0;
    bus.inta_n = 1'b1;
    bus.masked_irr = 8'h00;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
